// File: rtl/calc_control_unit.sv
// Calculator front end: three debounced pushbuttons drive a field-select FSM that
// edits two operands and an op code, then captures the ULA result for display.
module calc_control_unit #(
  parameter int WIDTH    = 4,
  parameter int MAXVAL   = 9,
  parameter int NUM_OPS  = 5,
  parameter int DEBOUNCE = 16,
  parameter int HOLD     = 64,
  parameter int REPEAT   = 16,
  parameter int ULA_LAT  = 1
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [2:0]         KEY,
  input  logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [3:0]         op,
  output logic [1:0]         field,
  output logic [2*WIDTH-1:0] number,
  output logic               res_valid
);

  localparam int DCW  = $clog2(DEBOUNCE + 1);
  localparam int RMAX = (HOLD > REPEAT) ? HOLD : REPEAT;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam int LCW  = $clog2(ULA_LAT + 2);

  typedef enum logic [1:0] {K_UP, K_DOWN, K_LOCK} key_state_e;
  typedef enum logic [1:0] {SEL_A = 2'd0, SEL_B = 2'd1, SEL_OP = 2'd2, SHOW = 2'd3} field_e;

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] key_pulse;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  // K_LOCK behaves like a held key without repeat, so a key held through reset
  // must be released (debounced) before it can be accepted again.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      localparam bit REP_EN = (gi != 2);

      key_state_e     kst_q, kst_d;
      logic [DCW-1:0] dcnt_q, dcnt_d;
      logic [RCW-1:0] rcnt_q, rcnt_d;
      logic           first_q, first_d;
      logic           pulse_q, pulse_d;

      always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
          kst_q   <= K_LOCK;
          dcnt_q  <= '0;
          rcnt_q  <= '0;
          first_q <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          kst_q   <= kst_d;
          dcnt_q  <= dcnt_d;
          rcnt_q  <= rcnt_d;
          first_q <= first_d;
          pulse_q <= pulse_d;
        end
      end

      always_comb begin
        kst_d   = kst_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        first_d = first_q;
        pulse_d = 1'b0;
        case (kst_q)
          K_UP: begin
            if (!sync2_q[gi]) begin
              if (dcnt_q == DCW'(DEBOUNCE - 1)) begin
                kst_d   = K_DOWN;
                dcnt_d  = '0;
                rcnt_d  = '0;
                first_d = 1'b1;
                pulse_d = 1'b1;
              end else begin
                dcnt_d = dcnt_q + DCW'(1);
              end
            end else begin
              dcnt_d = '0;
            end
          end
          K_DOWN, K_LOCK: begin
            if (sync2_q[gi]) begin
              if (dcnt_q == DCW'(DEBOUNCE - 1)) begin
                kst_d  = K_UP;
                dcnt_d = '0;
              end else begin
                dcnt_d = dcnt_q + DCW'(1);
              end
            end else begin
              dcnt_d = '0;
              if (REP_EN && (kst_q == K_DOWN)) begin
                if (rcnt_q == (first_q ? RCW'(HOLD - 1) : RCW'(REPEAT - 1))) begin
                  pulse_d = 1'b1;
                  rcnt_d  = '0;
                  first_d = 1'b0;
                end else begin
                  rcnt_d = rcnt_q + RCW'(1);
                end
              end
            end
          end
          default: kst_d = K_LOCK;
        endcase
      end

      assign key_pulse[gi] = pulse_q;
    end
  endgenerate

  logic inc, dec, nxt, step_up, step_dn;

  assign inc     = key_pulse[0];
  assign dec     = key_pulse[1];
  assign nxt     = key_pulse[2];
  assign step_up = inc & ~dec;
  assign step_dn = dec & ~inc;

  field_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] show_q, show_d;
  logic               res_valid_q, res_valid_d;
  logic [LCW-1:0]     lat_q, lat_d;

  function automatic logic [WIDTH-1:0] opnd_step(input logic [WIDTH-1:0] v, input logic up);
    if (up) return (v == WIDTH'(MAXVAL)) ? '0 : v + WIDTH'(1);
    else    return (v == '0) ? WIDTH'(MAXVAL) : v - WIDTH'(1);
  endfunction

  function automatic logic [3:0] op_step(input logic [3:0] v, input logic up);
    if (up) return (v == 4'(NUM_OPS - 1)) ? 4'd0 : v + 4'd1;
    else    return (v == 4'd0) ? 4'(NUM_OPS - 1) : v - 4'd1;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q     <= SEL_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      show_q      <= '0;
      res_valid_q <= 1'b0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      show_q      <= show_d;
      res_valid_q <= res_valid_d;
      lat_q       <= lat_d;
    end
  end

  // A next pulse wins over inc/dec and restarts the result capture sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    show_d      = show_q;
    res_valid_d = res_valid_q;
    lat_d       = lat_q;
    if (nxt) begin
      case (state_q)
        SEL_A:   state_d = SEL_B;
        SEL_B:   state_d = SEL_OP;
        SEL_OP:  state_d = SHOW;
        default: state_d = SEL_A;
      endcase
      res_valid_d = 1'b0;
      lat_d       = '0;
      show_d      = '0;
    end else begin
      case (state_q)
        SEL_A: if (step_up || step_dn) a_d = opnd_step(a_q, step_up);
        SEL_B: if (step_up || step_dn) b_d = opnd_step(b_q, step_up);
        SEL_OP: if (step_up || step_dn) op_d = op_step(op_q, step_up);
        default: begin
          if (!res_valid_q) begin
            if (lat_q == LCW'(ULA_LAT)) begin
              show_d      = result;
              res_valid_d = 1'b1;
            end else begin
              lat_d = lat_q + LCW'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    number = '0;
    case (state_q)
      SEL_A:   number = (2*WIDTH)'(a_q);
      SEL_B:   number = (2*WIDTH)'(b_q);
      SEL_OP:  number = (2*WIDTH)'(op_q);
      default: number = show_q;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign field     = state_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_calc_control_unit.sv
// Directed plus randomized key sequences for calc_control_unit, checked against
// an arithmetic model of operands, field and displayed value.
module tb_calc_control_unit;

  localparam int WIDTH    = 4;
  localparam int MAXVAL   = 9;
  localparam int NUM_OPS  = 5;
  localparam int DEBOUNCE = 4;
  localparam int HOLD     = 8;
  localparam int REPEAT   = 4;
  localparam int ULA_LAT  = 1;
  localparam int HELD     = 28;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         key;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a, b;
  logic [3:0]         op;
  logic [1:0]         field;
  logic [2*WIDTH-1:0] number;
  logic               res_valid;

  int errors = 0;
  int checks = 0;
  int m_a = 0, m_b = 0, m_op = 0, m_field = 0, m_show = 0, m_valid = 0;

  always #5 clk = ~clk;

  calc_control_unit #(
    .WIDTH(WIDTH), .MAXVAL(MAXVAL), .NUM_OPS(NUM_OPS), .DEBOUNCE(DEBOUNCE),
    .HOLD(HOLD), .REPEAT(REPEAT), .ULA_LAT(ULA_LAT)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .KEY(key), .result(result),
    .a(a), .b(b), .op(op), .field(field), .number(number), .res_valid(res_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_number();
    case (m_field)
      0: return m_a;
      1: return m_b;
      2: return m_op;
      default: return (m_valid != 0) ? m_show : 0;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_a"}, a, m_a);
    check({tag, "_b"}, b, m_b);
    check({tag, "_op"}, op, m_op);
    check({tag, "_field"}, field, m_field);
    check({tag, "_number"}, number, m_number());
    check({tag, "_valid"}, res_valid, m_valid);
  endtask

  // k: 0 inc, 1 dec, 2 next, 3 inc+dec together
  function automatic void model_key(input int k);
    int d;
    if (k == 2) begin
      m_field = (m_field + 1) % 4;
      m_valid = (m_field == 3) ? 1 : 0;
      if (m_field == 3) m_show = int'(result);
    end else if (k < 2) begin
      d = (k == 0) ? 1 : MAXVAL;
      case (m_field)
        0: m_a = (m_a + d) % (MAXVAL + 1);
        1: m_b = (m_b + d) % (MAXVAL + 1);
        2: m_op = (m_op + ((k == 0) ? 1 : NUM_OPS - 1)) % NUM_OPS;
        default: ;
      endcase
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, input int lo, input int hi);
    key = ~mask;
    cycles(lo);
    key = 3'b111;
    cycles(hi);
    $display("t=%0t press mask=%b lo=%0d hi=%0d a=%0d b=%0d op=%0d field=%0d number=%0d valid=%0b",
             $time, mask, lo, hi, a, b, op, field, number, res_valid);
  endtask

  function automatic logic [2:0] mask_of(input int k);
    case (k)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b011;
    endcase
  endfunction

  initial begin
    int t;
    int k;
    int exp_q[$];
    int got_q[$];
    logic [WIDTH-1:0] prev;

    key = 3'b111;
    result = '0;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_state("reset");
    cycles(10);

    // ten clean increments wrap a through 9 back to 0
    for (int i = 0; i < 10; i++) begin
      press(3'b001, $urandom_range(6, 11), $urandom_range(10, 16));
      model_key(0);
      check("inc_a", a, m_a);
      check("inc_number", number, m_a);
    end

    // short glitches never reach the debounce threshold
    for (int i = 0; i < 4; i++) begin
      key = 3'b110;
      cycles(3);
      key = 3'b111;
      cycles(6);
      $display("t=%0t bounce %0d a=%0d", $time, i, a);
      check("bounce_a", a, m_a);
    end
    cycles(10);

    // hold: record offsets of every a change relative to the first one
    for (int tt = HOLD; tt <= HELD; tt += REPEAT) exp_q.push_back(tt);
    exp_q.push_front(0);
    key = 3'b110;
    t = 0;
    while (a == WIDTH'(m_a) && t < 40) begin
      cycles(1);
      t++;
    end
    check("hold_first_pulse_seen", (t < 40), 1);
    got_q.push_back(0);
    prev = a;
    for (int kk = 1; kk <= 40; kk++) begin
      cycles(1);
      if (a != prev) got_q.push_back(kk);
      prev = a;
      if (kk == HELD - 1) key = 3'b111;
    end
    $display("t=%0t hold pulses=%0d a=%0d", $time, got_q.size(), a);
    check("hold_pulse_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("hold_offset%0d", i), got_q[i], exp_q[i]);
    m_a = (m_a + exp_q.size()) % (MAXVAL + 1);
    check("hold_a", a, m_a);
    cycles(10);

    // set up a=3, b=4, op=0
    for (int i = 0; i < 4; i++) begin press(3'b010, 8, 12); model_key(1); end
    press(3'b100, 8, 12); model_key(2);
    for (int i = 0; i < 4; i++) begin press(3'b001, 8, 12); model_key(0); end
    press(3'b100, 8, 12); model_key(2);
    check_state("setup");

    // SHOW entry: result captured exactly ULA_LAT+1 cycles after field reaches 3
    result = 8'hA5;
    key = 3'b011;
    t = 0;
    while (field != 2'd3 && t < 40) begin
      cycles(1);
      t++;
    end
    check("show_entry_seen", (t < 40), 1);
    check("show_s0_number", number, 0);
    check("show_s0_valid", res_valid, 0);
    cycles(1);
    check("show_s1_number", number, 0);
    check("show_s1_valid", res_valid, 0);
    result = 8'd7;
    cycles(1);
    check("show_s2_number", number, 7);
    check("show_s2_valid", res_valid, 1);
    result = 8'h3C;
    cycles(1);
    check("show_s3_number", number, 7);
    cycles(30);
    key = 3'b111;
    cycles(14);
    $display("t=%0t show field=%0d number=%0d valid=%0b", $time, field, number, res_valid);
    m_field = 3; m_show = 7; m_valid = 1;
    check_state("show_hold_next");

    press(3'b100, 8, 12); model_key(2);
    check_state("leave_show");
    press(3'b100, 8, 12); model_key(2);
    press(3'b011, 8, 12); model_key(3);
    check_state("cancel");
    press(3'b101, 8, 12); model_key(2);
    check_state("next_priority");

    // random walk
    for (int i = 0; i < 24; i++) begin
      result = 8'($urandom_range(0, 255));
      k = $urandom_range(0, 3);
      press(mask_of(k), $urandom_range(6, 11), $urandom_range(10, 16));
      model_key(k);
      check_state($sformatf("rand%0d", i));
    end

    // reset while KEY[0] is held mid-repeat
    key = 3'b110;
    cycles(20);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    m_a = 0; m_b = 0; m_op = 0; m_field = 0; m_show = 0; m_valid = 0;
    check_state("rst_held");
    cycles(30);
    $display("t=%0t held after reset a=%0d field=%0d", $time, a, field);
    check_state("rst_still_held");
    key = 3'b111;
    cycles(14);
    press(3'b001, 8, 12); model_key(0);
    check_state("rst_repress");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_control_unit.md
CALC_CONTROL_UNIT -- requirements
Module: calc_control_unit

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 4, operand width in bits.
REQ-002 The block SHALL expose parameter MAXVAL, default 9, largest operand value before wrap.
REQ-003 The block SHALL expose parameter NUM_OPS, default 5, number of ULA operations (op codes 0..NUM_OPS-1).
REQ-004 The block SHALL expose parameter DEBOUNCE, default 16, stable-cycles needed to accept a key press.
REQ-005 The block SHALL expose parameter HOLD, default 64, held-cycles before auto-repeat starts.
REQ-006 The block SHALL expose parameter REPEAT, default 16, cycles between auto-repeat pulses.
REQ-007 The block SHALL expose parameter ULA_LAT, default 1, ULA result latency in cycles.
REQ-008 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-009 RESET  input  1  reset, synchronous, active-high.
REQ-010 KEY  input  3  raw active-low pushbuttons: [0] increment, [1] decrement, [2] next field.
REQ-011 result  input  2*WIDTH  ULA result.
REQ-012 a  output  WIDTH  first operand to ULA.
REQ-013 b  output  WIDTH  second operand to ULA.
REQ-014 op  output  4  operation code to ULA.
REQ-015 field  output  2  current FSM state: 0 SEL_A, 1 SEL_B, 2 SEL_OP, 3 SHOW.
REQ-016 number  output  2*WIDTH  value for the display block.
REQ-017 res_valid  output  1  high when number holds a captured ULA result.

Function
REQ-018 Each KEY bit SHALL pass a 2-flop synchronizer before any use.
REQ-019 A press SHALL be accepted when the synchronized level is low for DEBOUNCE consecutive cycles, producing exactly one internal pulse per press.
REQ-020 Release SHALL require DEBOUNCE consecutive high cycles before a new press can be accepted.
REQ-021 If KEY[0] or KEY[1] stays accepted-pressed, an extra pulse SHALL occur HOLD cycles after the first pulse, then every REPEAT cycles until release; KEY[2] SHALL never auto-repeat.
REQ-022 FSM transitions on a next pulse: SEL_A->SEL_B->SEL_OP->SHOW->SEL_A.
REQ-023 In SEL_A/SEL_B an inc pulse SHALL add 1 to a/b, wrapping MAXVAL->0; a dec pulse SHALL subtract 1, wrapping 0->MAXVAL.
REQ-024 In SEL_OP inc/dec SHALL step op with wrap between NUM_OPS-1 and 0.
REQ-025 In SHOW inc/dec pulses SHALL be ignored.
REQ-026 Inc and dec pulses in the same cycle SHALL cancel (no change).
REQ-027 A next pulse in the same cycle as inc/dec SHALL take priority; the field changes and no value changes.
REQ-028 number SHALL equal zero-extended a in SEL_A, b in SEL_B, op in SEL_OP.
REQ-029 On SHOW entry res_valid SHALL drop; exactly ULA_LAT+1 cycles later result SHALL be latched into number and res_valid set; number SHALL hold 0 until then.
REQ-030 Leaving SHOW SHALL clear res_valid the following cycle.
REQ-031 Operand arithmetic SHALL be modulo the wrap range; MAXVAL > 2^WIDTH-1 is illegal.

Reset
REQ-032 With RESET high at a clock edge: a=0, b=0, op=0, field=0, number=0, res_valid=0, all debounce/repeat counters cleared, synchronizers set to released.
REQ-033 RESET SHALL abort any press in progress; a key still held after reset SHALL produce no pulse until released and re-pressed.

Verification (DEBOUNCE=4, HOLD=8, REPEAT=4, ULA_LAT=1, MAXVAL=9)
REQ-034 RESET 1 cycle, then 10 clean KEY[0] presses in SEL_A -> a steps 1..9 then 0.
REQ-035 KEY[0] pulsed low 3 cycles (bounce), repeated -> a unchanged.
REQ-036 KEY[0] held 30 cycles after debounce -> pulses at +0, +8, +12, +16, +20, +24, +28 -> a=7.
REQ-037 a=3, b=4, op=0 via KEY[2]x3 into SHOW, ULA returns 7 -> number=7, res_valid=1 exactly 2 cycles after field=3.
REQ-038 KEY[0] and KEY[1] accepted same cycle in SEL_B -> b unchanged; KEY[2] with KEY[0] same cycle -> field advances, b unchanged.
REQ-039 RESET asserted while KEY[0] held mid-repeat -> all outputs 0, no pulse until release and new press.
